toffli_op_sequencer: RTL and testbench
======================================

Name: toffli_op_sequencer

Overview:
- Controller that turns one reversible Toffoli gate array into a small logic ALU.
- Accepts an opcode and two operands over a valid/ready request handshake.
- Sequences 1–4 passes through an external Toffli instance by steering constants, operands and its own captured temporaries onto the gate's A/B/C inputs.
- Returns the result over a valid/ready response handshake.
- Performs no logic on operand data itself; all computation happens in the gate (R = C ^ (A & B)).

Parameters:
W, 32, operand/result width; matches Toffli A/B/C/R width
TOF_LAT, 1, register stages inside the Toffli instance (input sample edge to R valid); legal 1..7

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  3  opcode
req_a  in  W  operand a
req_b  in  W  operand b
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_data  out  W  result
rsp_err  out  1  reserved opcode flag, qualified by rsp_valid
busy  out  1  high in any state other than IDLE
tof_a  out  W  to Toffli A
tof_b  out  W  to Toffli B
tof_c  out  W  to Toffli C
tof_r  in  W  from Toffli R (P, Q unused)

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE; tof_a/b/c, rsp_data, t0, t1 = 0; rsp_valid=0, rsp_err=0, busy=0.
- Reset mid-operation: IDLE after the reset edge; the in-flight pass and any later tof_r value are discarded; no response is issued.
- States: IDLE, LOAD, WAIT, RESP.
- req_ready = (state==IDLE). Accept on req_valid & req_ready; latch op, a, b; pass index k=1; go LOAD.
- Reserved op (7): go straight to RESP with rsp_data=0 and rsp_err=1. rsp_valid is high after the accept edge +1. tof_* are untouched.
- LOAD: on the next edge, load the pass-k triple into tof_a/b/c, set cnt=TOF_LAT, go WAIT.
- WAIT: each edge with cnt!=0 decrements cnt. On the edge where cnt==0, capture tof_r:
  - into t0 for pass 1 and pass 3 of NOR;
  - into t1 for pass 2;
  - into rsp_data for the final pass.
  - After capture: if more passes remain, k++ and go LOAD; otherwise go RESP with rsp_valid=1 and rsp_err=0.
- Capture timing: tof_r is captured TOF_LAT+1 edges after the load edge. Each pass costs TOF_LAT+2 cycles. Accept to rsp_valid = passes*(TOF_LAT+2) cycles.
- tof_* hold their last loaded value between passes and after completion.
- RESP: rsp_valid, rsp_data and rsp_err are held stable until rsp_ready is high. On that handshake edge, drop rsp_valid and go IDLE. No new request is accepted in the same cycle.
- Pass table, as (tof_a, tof_b, tof_c); 1s = all-ones:
  - 0 AND: (a, b, 0)
  - 1 NAND: (a, b, 1s)
  - 2 XOR: (1s, a, b)
  - 3 XNOR: (1s, a, b)→t0; (1s, 1s, t0)
  - 4 NOT a: (1s, 1s, a)
  - 5 OR: (1s, 1s, a)→t0; (1s, 1s, b)→t1; (t0, t1, 1s)
  - 6 NOR: the three OR passes, with pass 3→t0; then (1s, 1s, t0)
- Pass counts: 1,1,1,2,1,3,4,reserved.
- Request inputs are ignored while not in IDLE. rsp_ready is ignored outside RESP.

Test Plan:
1. AND, a=AAAAAAAA, b=55555555, TOF_LAT=1 -> tof_c=00000000 during the pass; rsp_data=00000000, rsp_err=0; rsp_valid exactly 3 cycles after accept.
2. NAND a=b=FFFFFFFF -> 00000000. Back-to-back after the handshake, XOR a=12345678, b=87654321 -> 95511559. req_ready is low throughout each operation.
3. OR, a=0F0F0F0F, b=F0F0F0F0 -> tof_c=0F0F0F0F on pass 1 and F0F0F0F0 on pass 2; pass 3 has tof_a=F0F0F0F0, tof_b=0F0F0F0F; rsp_data=FFFFFFFF at 9 cycles. Repeat with TOF_LAT=3 -> 15 cycles.
4. NOR, a=00FF00FF, b=ABCDEF01 -> rsp_data=54001000 at 12 cycles (TOF_LAT=1).
5. XNOR, a=b=FFFFFFFF, rsp_ready held low 5 cycles -> rsp_valid and rsp_data=FFFFFFFF stable and busy=1 throughout; IDLE the cycle after rsp_ready rises.
6. Assert rst during OR pass 2 -> IDLE, req_ready=1, tof_*=0, no rsp_valid. Then op 7 -> rsp_valid one cycle after accept, rsp_err=1, rsp_data=0, tof_* unchanged.

Source files
------------

// File: rtl/toffli_op_sequencer.sv
// Logic ALU built around one external Toffoli gate array (R = C ^ (A & B)).
// The sequencer only steers constants, latched operands and captured temporaries
// onto the gate inputs; every bit of computation happens inside the gate.
module toffli_op_sequencer #(
   parameter int unsigned W       = 32,
   parameter int unsigned TOF_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_err,
   output logic         busy,
   output logic [W-1:0] tof_a,
   output logic [W-1:0] tof_b,
   output logic [W-1:0] tof_c,
   input  logic [W-1:0] tof_r
);

   typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_e;

   localparam logic [2:0] OpAnd  = 3'd0;
   localparam logic [2:0] OpNand = 3'd1;
   localparam logic [2:0] OpXor  = 3'd2;
   localparam logic [2:0] OpXnor = 3'd3;
   localparam logic [2:0] OpNot  = 3'd4;
   localparam logic [2:0] OpOr   = 3'd5;
   localparam logic [2:0] OpNor  = 3'd6;
   localparam logic [2:0] OpRsvd = 3'd7;

   state_e       state;
   logic [2:0]   op_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [W-1:0] t0;
   logic [W-1:0] t1;
   logic [1:0]   pass_q;   // zero-based pass index (k-1)
   logic [2:0]   cnt;

   logic [W-1:0] nxt_a;
   logic [W-1:0] nxt_b;
   logic [W-1:0] nxt_c;
   logic [1:0]   last_pass;

   assign req_ready = (state == StIdle);

   // Gate input triple for the current pass, and index of the final pass.
   always_comb begin
      nxt_a     = '1;
      nxt_b     = '1;
      nxt_c     = '1;
      last_pass = 2'd0;
      case (op_q)
         OpAnd: begin
            nxt_a = a_q;
            nxt_b = b_q;
            nxt_c = '0;
         end
         OpNand: begin
            nxt_a = a_q;
            nxt_b = b_q;
         end
         OpXor: begin
            nxt_b = a_q;
            nxt_c = b_q;
         end
         OpXnor: begin
            last_pass = 2'd1;
            if (pass_q == 2'd0) begin
               nxt_b = a_q;
               nxt_c = b_q;
            end else begin
               nxt_c = t0;
            end
         end
         OpNot: begin
            nxt_c = a_q;
         end
         OpOr, OpNor: begin
            // ~a -> t0, ~b -> t1, then t0 & t1 inverted gives a | b
            last_pass = (op_q == OpNor) ? 2'd3 : 2'd2;
            case (pass_q)
               2'd0: nxt_c = a_q;
               2'd1: nxt_c = b_q;
               2'd2: begin
                  nxt_a = t0;
                  nxt_b = t1;
               end
               default: nxt_c = t0;
            endcase
         end
         default: ;
      endcase
   end

   // Control FSM and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         t0        <= '0;
         t1        <= '0;
         pass_q    <= '0;
         cnt       <= '0;
         tof_a     <= '0;
         tof_b     <= '0;
         tof_c     <= '0;
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (req_valid) begin
                  op_q   <= req_op;
                  a_q    <= req_a;
                  b_q    <= req_b;
                  pass_q <= 2'd0;
                  busy   <= 1'b1;
                  state  <= StLoad;
               end
            end
            StLoad: begin
               if (op_q == OpRsvd) begin
                  // Reserved op never touches the gate.
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= StResp;
               end else begin
                  tof_a <= nxt_a;
                  tof_b <= nxt_b;
                  tof_c <= nxt_c;
                  cnt   <= 3'(TOF_LAT);
                  state <= StWait;
               end
            end
            StWait: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else if (pass_q == last_pass) begin
                  rsp_data  <= tof_r;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= StResp;
               end else begin
                  if (pass_q == 2'd1) begin
                     t1 <= tof_r;
                  end else begin
                     t0 <= tof_r;
                  end
                  pass_q <= pass_q + 2'd1;
                  state  <= StLoad;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_toffli_op_sequencer.sv
// Bench for toffli_op_sequencer: two DUTs (gate latency 1 and 3) each driving a
// behavioural Toffoli pipeline; a select bit routes the shared stimulus to one.
module tb_toffli_op_sequencer;

   localparam int L1 = 1;
   localparam int L3 = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  req_op = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        rsp_ready = 1'b0;

   logic        u1_req_ready, u1_rsp_valid, u1_rsp_err, u1_busy;
   logic [31:0] u1_rsp_data, u1_a, u1_b, u1_c, u1_r;
   logic        u3_req_ready, u3_rsp_valid, u3_rsp_err, u3_busy;
   logic [31:0] u3_rsp_data, u3_a, u3_b, u3_c, u3_r;

   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_data, tof_a, tof_b, tof_c;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   toffli_op_sequencer #(.W(32), .TOF_LAT(L1)) u1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & ~sel), .req_ready(u1_req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(u1_rsp_valid), .rsp_ready(rsp_ready & ~sel),
      .rsp_data(u1_rsp_data), .rsp_err(u1_rsp_err), .busy(u1_busy),
      .tof_a(u1_a), .tof_b(u1_b), .tof_c(u1_c), .tof_r(u1_r)
   );

   toffli_op_sequencer #(.W(32), .TOF_LAT(L3)) u3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & sel), .req_ready(u3_req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(u3_rsp_valid), .rsp_ready(rsp_ready & sel),
      .rsp_data(u3_rsp_data), .rsp_err(u3_rsp_err), .busy(u3_busy),
      .tof_a(u3_a), .tof_b(u3_b), .tof_c(u3_c), .tof_r(u3_r)
   );

   // Behavioural Toffoli gates with TOF_LAT register stages.
   logic [31:0] p1 [L1];
   logic [31:0] p3 [L3];
   always @(posedge clk) begin
      p1[0] <= u1_c ^ (u1_a & u1_b);
   end
   always @(posedge clk) begin
      p3[0] <= u3_c ^ (u3_a & u3_b);
      for (int i = 1; i < L3; i++) p3[i] <= p3[i-1];
   end
   assign u1_r = p1[L1-1];
   assign u3_r = p3[L3-1];

   assign req_ready = sel ? u3_req_ready : u1_req_ready;
   assign rsp_valid = sel ? u3_rsp_valid : u1_rsp_valid;
   assign rsp_err   = sel ? u3_rsp_err   : u1_rsp_err;
   assign busy      = sel ? u3_busy      : u1_busy;
   assign rsp_data  = sel ? u3_rsp_data  : u1_rsp_data;
   assign tof_a     = sel ? u3_a : u1_a;
   assign tof_b     = sel ? u3_b : u1_b;
   assign tof_c     = sel ? u3_c : u1_c;

   // Reference model: what each opcode means and how many gate passes it costs.
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, b);
      case (op)
         3'd0: return a & b;
         3'd1: return ~(a & b);
         3'd2: return a ^ b;
         3'd3: return ~(a ^ b);
         3'd4: return ~a;
         3'd5: return a | b;
         3'd6: return ~(a | b);
         default: return 32'h0;
      endcase
   endfunction

   function automatic int ref_cyc(input logic [2:0] op, input int lat);
      int passes [8] = '{1, 1, 1, 2, 1, 3, 4, 0};
      if (op == 3'd7) return 1;
      return passes[op] * (lat + 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Issue one request, then wait (bounded) for rsp_valid; cyc = edges from accept.
   task automatic do_op(input logic s, input logic [2:0] op, input logic [31:0] a, b,
                        input bit noise, output int cyc);
      int w = 0;
      bit bad = 0;
      sel = s;
      while (!req_ready && w < 50) begin
         tick();
         w++;
      end
      req_op = op;
      req_a = a;
      req_b = b;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 300) begin
         if (req_ready !== 1'b0 || busy !== 1'b1) bad = 1;
         if (noise) begin
            req_valid = 1'($urandom);
            req_op = 3'($urandom);
            req_a = $urandom;
            req_b = $urandom;
         end
         tick();
         cyc++;
      end
      req_valid = 1'b0;
      chk("busy_while_op", 32'(bad), 32'd0);
   endtask

   task automatic finish_rsp(input int dly);
      repeat (dly) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic        s;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        err;
      int          cyc;
   } vec_t;

   vec_t vt [12];

   initial begin
      int cyc;
      bit bad;
      logic [31:0] d0;

      vt[0]  = '{1'b0, 3'd0, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b0, 3};
      vt[1]  = '{1'b0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 3};
      vt[2]  = '{1'b0, 3'd2, 32'h12345678, 32'h87654321, 32'h95511559, 1'b0, 3};
      vt[3]  = '{1'b0, 3'd5, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0, 9};
      vt[4]  = '{1'b1, 3'd5, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0, 15};
      vt[5]  = '{1'b0, 3'd6, 32'h00FF00FF, 32'hABCDEF01, 32'h54001000, 1'b0, 12};
      vt[6]  = '{1'b0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 6};
      vt[7]  = '{1'b0, 3'd4, 32'h12345678, 32'h00000000, 32'hEDCBA987, 1'b0, 3};
      vt[8]  = '{1'b1, 3'd6, 32'h00FF00FF, 32'hABCDEF01, 32'h54001000, 1'b0, 20};
      vt[9]  = '{1'b0, 3'd7, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1};
      vt[10] = '{1'b1, 3'd3, 32'h12345678, 32'h87654321, 32'h6AAEEAA6, 1'b0, 10};
      vt[11] = '{1'b1, 3'd7, 32'hDEADBEEF, 32'h0BADF00D, 32'h00000000, 1'b1, 1};

      // Reset state on both instances.
      repeat (3) tick();
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #0;
         chk("rst_req_ready", 32'(req_ready), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rsp_err", 32'(rsp_err), 32'd0);
         chk("rst_rsp_data", rsp_data, 32'd0);
         chk("rst_tof_abc", tof_a | tof_b | tof_c, 32'd0);
      end
      sel = 1'b0;
      rst = 1'b0;
      tick();

      // Table vectors, run back to back.
      foreach (vt[i]) begin
         do_op(vt[i].s, vt[i].op, vt[i].a, vt[i].b, 1'b0, cyc);
         chk("vec_cycles", 32'(cyc), 32'(vt[i].cyc));
         chk("vec_data", rsp_data, vt[i].exp);
         chk("vec_err", 32'(rsp_err), 32'(vt[i].err));
         finish_rsp(0);
      end

      // AND gate triple during its single pass, and hold after completion.
      sel = 1'b0;
      req_op = 3'd0; req_a = 32'hAAAAAAAA; req_b = 32'h55555555; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("and_tof_a", tof_a, 32'hAAAAAAAA);
      chk("and_tof_b", tof_b, 32'h55555555);
      chk("and_tof_c", tof_c, 32'h00000000);
      tick();
      chk("and_not_yet", 32'(rsp_valid), 32'd0);
      tick();
      chk("and_valid_at3", 32'(rsp_valid), 32'd1);
      finish_rsp(0);
      chk("and_hold_tof_a", tof_a, 32'hAAAAAAAA);

      // OR gate triples per pass with TOF_LAT=1.
      req_op = 3'd5; req_a = 32'h0F0F0F0F; req_b = 32'hF0F0F0F0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("or_p1_c", tof_c, 32'h0F0F0F0F);
      repeat (3) tick();
      chk("or_p2_c", tof_c, 32'hF0F0F0F0);
      repeat (3) tick();
      chk("or_p3_a", tof_a, 32'hF0F0F0F0);
      chk("or_p3_b", tof_b, 32'h0F0F0F0F);
      chk("or_p3_c", tof_c, 32'hFFFFFFFF);
      repeat (2) tick();
      chk("or_valid_at9", 32'(rsp_valid), 32'd1);
      chk("or_data", rsp_data, 32'hFFFFFFFF);
      finish_rsp(0);

      // XNOR with a stalled consumer.
      do_op(1'b0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc);
      d0 = rsp_data;
      chk("xnor_data", d0, 32'hFFFFFFFF);
      bad = 0;
      repeat (5) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFFFFFF || busy !== 1'b1 ||
             rsp_err !== 1'b0 || req_ready !== 1'b0) bad = 1;
      end
      chk("xnor_stall_stable", 32'(bad), 32'd0);
      finish_rsp(0);

      // Reset during OR pass 2, then a reserved op.
      req_op = 3'd5; req_a = 32'h0F0F0F0F; req_b = 32'hF0F0F0F0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (5) tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_tof", tof_a | tof_b | tof_c, 32'd0);
      bad = 0;
      repeat (10) begin
         tick();
         if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      chk("mid_rst_no_rsp", 32'(bad), 32'd0);
      do_op(1'b0, 3'd7, 32'h12345678, 32'h9ABCDEF0, 1'b0, cyc);
      chk("rsvd_cycles", 32'(cyc), 32'd1);
      chk("rsvd_err", 32'(rsp_err), 32'd1);
      chk("rsvd_data", rsp_data, 32'd0);
      chk("rsvd_tof", tof_a | tof_b | tof_c, 32'd0);
      finish_rsp(2);

      // Randomised traffic against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic        s;
         logic [2:0]  op;
         logic [31:0] a, b;
         s  = 1'($urandom);
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         do_op(s, op, a, b, 1'b1, cyc);
         chk("rnd_cycles", 32'(cyc), 32'(ref_cyc(op, s ? L3 : L1)));
         chk("rnd_data", rsp_data, ref_res(op, a, b));
         chk("rnd_err", 32'(rsp_err), 32'(op == 3'd7));
         finish_rsp($urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
